// File: rtl/mem_miss_handler_pkg.sv
// Shared memory-side definitions for the miss handler: state/owner encodings,
// block geometry and the memory request payload.
package mem_miss_handler_pkg;

  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned WORD_OFF_W  = 3;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BLK_ADDR_W  = ADDR_W - WORD_OFF_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic {
    ISIDE = 1'b0,
    DSIDE = 1'b1
  } owner_e;

  typedef struct packed {
    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/fill_counter.sv
// Small up-counter used to track issued and received block words.
module fill_counter
  import mem_miss_handler_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Clear wins over enable so the DONE cycle always restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_miss_handler.sv
// Arbitrates I/D cache misses and write-through stores onto the single-ported
// main memory and streams returning block words into the owning cache.
module mem_miss_handler
  import mem_miss_handler_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icache_miss,
  input  logic [15:0] icache_miss_addr,
  input  logic        dcache_miss,
  input  logic [15:0] dcache_miss_addr,
  input  logic        store_req,
  input  logic [15:0] store_addr,
  input  logic [15:0] store_data,
  output logic        store_ack,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_rdata,
  output logic        icache_fill_we,
  output logic        dcache_fill_we,
  output logic [2:0]  fill_word_idx,
  output logic [15:0] fill_data,
  output logic        icache_fill_done,
  output logic        dcache_fill_done,
  output logic        busy
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [BLK_ADDR_W-1:0] blk_addr_q, blk_addr_d;
  logic [CNT_W-1:0]      issue_cnt, rcv_cnt;
  logic                  issue_en, rcv_en, cnt_clr;
  mem_req_t              mem_req;
  logic                  unused_addr_bits;

  // The in-block offset of a miss address is irrelevant: whole blocks are fetched.
  assign unused_addr_bits = ^{icache_miss_addr[3:0], dcache_miss_addr[3:0]};

  fill_counter u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (issue_en),
    .cnt   (issue_cnt)
  );

  fill_counter u_rcv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (rcv_en),
    .cnt   (rcv_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= ISIDE;
      blk_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      blk_addr_q <= blk_addr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    blk_addr_d       = blk_addr_q;
    mem_req          = '0;
    store_ack        = 1'b0;
    issue_en         = 1'b0;
    rcv_en           = 1'b0;
    cnt_clr          = 1'b0;
    icache_fill_we   = 1'b0;
    dcache_fill_we   = 1'b0;
    fill_word_idx    = '0;
    fill_data        = '0;
    icache_fill_done = 1'b0;
    dcache_fill_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Store is gated by rst_n so every output is quiet while reset is held.
        if (dcache_miss) begin
          owner_d    = DSIDE;
          blk_addr_d = dcache_miss_addr[15:4];
          state_d    = ST_FILL;
        end else if (store_req && rst_n) begin
          mem_req   = '{en: 1'b1, wr: 1'b1, addr: store_addr, wdata: store_data};
          store_ack = 1'b1;
        end else if (icache_miss) begin
          owner_d    = ISIDE;
          blk_addr_d = icache_miss_addr[15:4];
          state_d    = ST_FILL;
        end
      end

      ST_FILL: begin
        if (issue_cnt < CNT_W'(BLOCK_WORDS)) begin
          issue_en      = 1'b1;
          mem_req.en    = 1'b1;
          mem_req.addr  = {blk_addr_q, issue_cnt[WORD_OFF_W-1:0], 1'b0};
        end
        if (mem_data_valid && (rcv_cnt < CNT_W'(BLOCK_WORDS))) begin
          rcv_en         = 1'b1;
          icache_fill_we = (owner_q == ISIDE);
          dcache_fill_we = (owner_q == DSIDE);
          fill_word_idx  = rcv_cnt[WORD_OFF_W-1:0];
          fill_data      = mem_rdata;
          // Leaving on the last word lands in DONE with rcv_cnt == 8.
          if (rcv_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        icache_fill_done = (owner_q == ISIDE);
        dcache_fill_done = (owner_q == DSIDE);
        cnt_clr          = 1'b1;
        state_d          = ST_IDLE;
      end

      default: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_en    = mem_req.en;
  assign mem_wr    = mem_req.wr;
  assign mem_addr  = mem_req.addr;
  assign mem_wdata = mem_req.wdata;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/mem_miss_handler.md
# mem_miss_handler

Cache-miss and memory-arbitration engine between the pipeline's instruction/data caches and the single-ported, 4-cycle-latency unified main memory. It accepts miss requests from the I-cache (fetch side) and D-cache (memory side), plus write-through stores from the memory stage. It streams 8-word (16-byte) blocks from memory back into the requesting cache. The pipeline holds its fetch and memory stages while the corresponding miss is outstanding.

## Interface
Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block. Fixed by the cache geometry and not varied.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- icache_miss  in  1  I-side miss; held high until icache_fill_done.
- icache_miss_addr  in  16  faulting fetch address; only bits [15:4] are used.
- dcache_miss  in  1  D-side miss; held high until dcache_fill_done.
- dcache_miss_addr  in  16  faulting data address; only bits [15:4] are used.
- store_req  in  1  write-through store request.
- store_addr  in  16  store byte address (word aligned).
- store_data  in  16  store data.
- store_ack  out  1  one-cycle pulse; the store was issued to memory this cycle.
- mem_en  out  1  memory access enable.
- mem_wr  out  1  1 = write, 0 = read; valid when mem_en = 1.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_data_valid  in  1  read data returning this cycle.
- mem_rdata  in  16  returned read data.
- icache_fill_we  out  1  write fill_data into the I-cache block.
- dcache_fill_we  out  1  write fill_data into the D-cache block.
- fill_word_idx  out  3  word index within the block being written.
- fill_data  out  16  word being written (mem_rdata, passed through).
- icache_fill_done  out  1  one-cycle pulse; the I-cache block is complete and the tag may be written.
- dcache_fill_done  out  1  one-cycle pulse; the D-cache block is complete.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FILL, DONE. The fill owner, ISIDE or DSIDE, is latched when the block leaves IDLE.
- IDLE arbitration, evaluated each cycle, priority dcache_miss > store_req > icache_miss:
  - dcache_miss: latch {dcache_miss_addr[15:4]}, owner = DSIDE, go to FILL.
  - store_req: drive mem_en=1, mem_wr=1, mem_addr=store_addr, mem_wdata=store_data, and store_ack=1 in the same cycle (combinational). Stay in IDLE.
  - icache_miss: latch the address, owner = ISIDE, go to FILL.
- FILL:
  - Issue counter issue_cnt runs 0..8. While issue_cnt < 8, drive mem_en=1, mem_wr=0, mem_addr={blk_addr, issue_cnt[2:0], 1'b0}, then increment.
  - Receive counter rcv_cnt runs 0..8. On each mem_data_valid: assert the owner's fill_we, set fill_word_idx=rcv_cnt[2:0] and fill_data=mem_rdata, then increment.
  - When rcv_cnt reaches 8, go to DONE.
- DONE: pulse the owner's fill_done for one cycle, clear both counters, return to IDLE.
- Requests and store_req arriving while not in IDLE are not accepted. Requesters hold them.
- A miss line that drops mid-fill does not abort the fill. Outstanding reads cannot be cancelled, and the block completes normally.
- mem_data_valid in IDLE or DONE is ignored, and so is any valid beyond the 8th word.
- Reset mid-operation: every state and counter returns to IDLE/0. Late data that arrives after reset is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, owner ISIDE.
- Miss seen in IDLE at cycle 0:
  - reads issued cycles 1–8 (word 0..7);
  - data valid cycles 5–12;
  - DONE in cycle 13, with fill_done high;
  - IDLE in cycle 14.
  - A request present in cycle 14 is issued in cycle 15.
- Store: 1 cycle, acknowledged in the cycle it is accepted.
- Fill outputs are combinational from mem_data_valid and the counters. There is no added latency.
- busy is registered-state-derived: high from cycle 1 through cycle 13.

## Structure
- A shared memory-defines package holds: state encoding (IDLE=2'b00, FILL=2'b01, DONE=2'b10), owner encoding, BLOCK_WORDS, and the word-offset width (3).
- One sub-module, fill_counter: a 4-bit up-counter with synchronous clear, enable, and asynchronous reset. It is instantiated twice, for issue and receive.

## Test plan
- icache_miss at addr 0x1234 from IDLE:
  - mem_addr 0x1230, 0x1232 … 0x123E on cycles 1–8;
  - icache_fill_we with idx 0..7 on cycles 5–12;
  - icache_fill_done pulse on cycle 13.
- dcache_miss and icache_miss raised in the same cycle: the D-block fills first. The I-fill starts the cycle after the block returns to IDLE (cycle 15 issue).
- store_req (0x0040, 0xBEEF) in IDLE: same-cycle mem_en=1, mem_wr=1, store_ack=1. store_req during FILL: no ack until the return to IDLE.
- Irregular mem_data_valid with gaps (e.g. valid on cycles 5, 7, 8, 10, 11, 13, 14, 16): word indices stay 0..7 in order, and fill_done follows the 8th valid by 1 cycle.
- rst_n asserted during FILL after 3 words: all outputs 0 immediately. Subsequent stray mem_data_valid produces no fill_we.
- Spurious mem_data_valid in IDLE: no fill_we, no state change.
